// File: rtl/sram_arb_pkg.sv
// Shared types and sizes for the SRAM line-bus arbiter.
package sram_arb_pkg;

  localparam int unsigned N_REQ    = 3;
  localparam int unsigned LINE_OFF = 5;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned TYPE_W   = 6;
  localparam int unsigned LINE_W   = 256;
  localparam int unsigned STRB_W   = 16;
  localparam int unsigned ID_W     = $clog2(N_REQ);
  localparam int unsigned TAG_W    = ADDR_W - LINE_OFF;

  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT} r_state_t;
  typedef enum logic       {W_IDLE, W_ISSUE}         w_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [TYPE_W-1:0] typ;
    logic [ID_W-1:0]   id;
  } rd_cmd_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] data;
    logic [TYPE_W-1:0] typ;
    logic [STRB_W-1:0] strb;
  } wr_cmd_t;

  // Line tag used for read-after-write hazard detection.
  function automatic logic [TAG_W-1:0] line_of(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1:LINE_OFF];
  endfunction

endpackage

// File: rtl/sram_arb_if.sv
// Upstream requester bus and downstream SRAM line bus.
interface sram_arb_if;
  import sram_arb_pkg::*;

  logic [N_REQ-1:0]        r_req;
  logic [ADDR_W*N_REQ-1:0] r_addr;
  logic [TYPE_W*N_REQ-1:0] r_type;
  logic [N_REQ-1:0]        r_rdy;
  logic [LINE_W-1:0]       re_data;
  logic [N_REQ-1:0]        re_valid;
  logic [N_REQ-1:0]        w_req;
  logic [ADDR_W*N_REQ-1:0] w_addr;
  logic [LINE_W*N_REQ-1:0] w_data;
  logic [TYPE_W*N_REQ-1:0] w_type;
  logic [STRB_W*N_REQ-1:0] w_strb;
  logic [N_REQ-1:0]        w_rdy;

  modport master (output r_req, r_addr, r_type, w_req, w_addr, w_data, w_type, w_strb,
                  input  r_rdy, re_data, re_valid, w_rdy);
  modport slave  (input  r_req, r_addr, r_type, w_req, w_addr, w_data, w_type, w_strb,
                  output r_rdy, re_data, re_valid, w_rdy);
endinterface

interface sram_arb_mem_if;
  import sram_arb_pkg::*;

  logic              m_r_req;
  logic [ADDR_W-1:0] m_r_addr;
  logic [TYPE_W-1:0] m_r_type;
  logic              m_r_rdy;
  logic [LINE_W-1:0] m_re_data;
  logic              m_re_valid;
  logic              m_w_req;
  logic [ADDR_W-1:0] m_w_addr;
  logic [LINE_W-1:0] m_w_data;
  logic [TYPE_W-1:0] m_w_type;
  logic [STRB_W-1:0] m_w_strb;
  logic              m_w_rdy;

  modport master (output m_r_req, m_r_addr, m_r_type, m_w_req, m_w_addr, m_w_data, m_w_type, m_w_strb,
                  input  m_r_rdy, m_re_data, m_re_valid, m_w_rdy);
  modport slave  (input  m_r_req, m_r_addr, m_r_type, m_w_req, m_w_addr, m_w_data, m_w_type, m_w_strb,
                  output m_r_rdy, m_re_data, m_re_valid, m_w_rdy);
endinterface

// File: rtl/sram_arb_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting at the stored pointer; pointer
// moves past the winner only when the caller reports a completed handshake.
module rr_arbiter
  import sram_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] i_req,
  input  logic             i_adv,
  output logic [N_REQ-1:0] o_gnt_c,
  output logic [ID_W-1:0]  o_idx_c
);

  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] w_ptr_nxt;
  logic [ID_W-1:0] w_j;
  logic            w_found;

  always_comb begin
    o_gnt_c = '0;
    o_idx_c = '0;
    w_found = 1'b0;
    w_j     = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      w_j = ID_W'((32'(r_ptr) + k) % N_REQ);
      if (!w_found && i_req[w_j]) begin
        w_found      = 1'b1;
        o_gnt_c[w_j] = 1'b1;
        o_idx_c      = w_j;
      end
    end
  end

  assign w_ptr_nxt = (o_idx_c == ID_W'(N_REQ - 1)) ? '0 : o_idx_c + ID_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_ptr <= '0;
    else if (i_adv && w_found)   r_ptr <= w_ptr_nxt;
  end

endmodule

// File: rtl/sram_arb.sv
// Shares one downstream SRAM line bus among N_REQ requesters with independent
// read/write channels, a one-entry posted write buffer and RAW line blocking.
module sram_arb
  import sram_arb_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  sram_arb_if.slave      up,
  sram_arb_mem_if.master dn
);

  logic [N_REQ-1:0] w_rgnt;
  logic [N_REQ-1:0] w_wgnt;
  logic [ID_W-1:0]  w_ridx;
  logic [ID_W-1:0]  w_widx;
  logic             w_rd_go;
  logic             w_wr_go;
  logic             w_re_fire;
  logic             w_haz;

  r_state_t r_rstate, w_rstate_nxt;
  w_state_t r_wstate, w_wstate_nxt;
  rd_cmd_t  r_rcmd, w_rcmd_nxt, w_rcmd_in;
  wr_cmd_t  r_wbuf, w_wbuf_nxt, w_wcmd_in;
  logic     r_m_r_req, w_m_r_req_nxt;
  logic     r_wbuf_vld, w_wbuf_vld_nxt;

  rr_arbiter u_rd_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_req  (up.r_req),
    .i_adv  (w_rd_go),
    .o_gnt_c(w_rgnt),
    .o_idx_c(w_ridx)
  );

  rr_arbiter u_wr_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_req  (up.w_req),
    .i_adv  (w_wr_go),
    .o_gnt_c(w_wgnt),
    .o_idx_c(w_widx)
  );

  // Payload of the current winner on each channel.
  always_comb begin
    w_rcmd_in.addr = up.r_addr[32'(w_ridx)*ADDR_W +: ADDR_W];
    w_rcmd_in.typ  = up.r_type[32'(w_ridx)*TYPE_W +: TYPE_W];
    w_rcmd_in.id   = w_ridx;
    w_wcmd_in.addr = up.w_addr[32'(w_widx)*ADDR_W +: ADDR_W];
    w_wcmd_in.data = up.w_data[32'(w_widx)*LINE_W +: LINE_W];
    w_wcmd_in.typ  = up.w_type[32'(w_widx)*TYPE_W +: TYPE_W];
    w_wcmd_in.strb = up.w_strb[32'(w_widx)*STRB_W +: STRB_W];
  end

  // A read must not overtake an undrained or just-accepted write to its line.
  assign w_haz = (r_wbuf_vld && (line_of(w_rcmd_in.addr) == line_of(r_wbuf.addr))) ||
                 (w_wr_go    && (line_of(w_rcmd_in.addr) == line_of(w_wcmd_in.addr)));

  always_comb begin
    w_wstate_nxt   = r_wstate;
    w_wbuf_nxt     = r_wbuf;
    w_wbuf_vld_nxt = r_wbuf_vld;
    w_wr_go        = 1'b0;
    unique case (r_wstate)
      W_IDLE: begin
        if (rst_n && (|w_wgnt)) begin
          w_wr_go        = 1'b1;
          w_wbuf_nxt     = w_wcmd_in;
          w_wbuf_vld_nxt = 1'b1;
          w_wstate_nxt   = W_ISSUE;
        end
      end
      W_ISSUE: begin
        if (dn.m_w_rdy) begin
          w_wbuf_vld_nxt = 1'b0;
          w_wstate_nxt   = W_IDLE;
        end
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    w_rstate_nxt  = r_rstate;
    w_rcmd_nxt    = r_rcmd;
    w_m_r_req_nxt = r_m_r_req;
    w_rd_go       = 1'b0;
    w_re_fire     = 1'b0;
    unique case (r_rstate)
      R_IDLE: begin
        if (rst_n && (|w_rgnt) && !w_haz) begin
          w_rd_go       = 1'b1;
          w_rcmd_nxt    = w_rcmd_in;
          w_m_r_req_nxt = 1'b1;
          w_rstate_nxt  = R_ISSUE;
        end
      end
      R_ISSUE: begin
        if (dn.m_r_rdy) begin
          w_m_r_req_nxt = 1'b0;
          w_rstate_nxt  = R_WAIT;
        end
      end
      R_WAIT: begin
        if (dn.m_re_valid) begin
          w_re_fire    = 1'b1;
          w_rstate_nxt = R_IDLE;
        end
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rstate  <= R_IDLE;
      r_rcmd    <= '0;
      r_m_r_req <= 1'b0;
    end else begin
      r_rstate  <= w_rstate_nxt;
      r_rcmd    <= w_rcmd_nxt;
      r_m_r_req <= w_m_r_req_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wstate   <= W_IDLE;
      r_wbuf     <= '0;
      r_wbuf_vld <= 1'b0;
    end else begin
      r_wstate   <= w_wstate_nxt;
      r_wbuf     <= w_wbuf_nxt;
      r_wbuf_vld <= w_wbuf_vld_nxt;
    end
  end

  assign up.r_rdy    = w_rd_go ? w_rgnt : '0;
  assign up.w_rdy    = w_wr_go ? w_wgnt : '0;
  assign up.re_valid = w_re_fire ? (N_REQ'(1) << r_rcmd.id) : '0;
  assign up.re_data  = w_re_fire ? dn.m_re_data : '0;

  assign dn.m_r_req  = r_m_r_req;
  assign dn.m_r_addr = r_rcmd.addr;
  assign dn.m_r_type = r_rcmd.typ;
  assign dn.m_w_req  = r_wbuf_vld;
  assign dn.m_w_addr = r_wbuf.addr;
  assign dn.m_w_data = r_wbuf.data;
  assign dn.m_w_type = r_wbuf.typ;
  assign dn.m_w_strb = r_wbuf.strb;

  // A read return is only legal once the request has been accepted downstream.
  a_no_early_return: assert property (@(posedge clk) disable iff (!rst_n)
    (r_rstate == R_ISSUE) |-> !dn.m_re_valid);

endmodule

// File: tb/tb_sram_arb.sv
// Directed bench for sram_arb: single read, contention, RAW blocking, posted writes, reset.
module tb_sram_arb;
  import sram_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sram_arb_if     up ();
  sram_arb_mem_if dn ();

  sram_arb dut (.clk(clk), .rst_n(rst_n), .up(up), .dn(dn));

  int checks = 0;
  int errors = 0;
  logic              auto_ret;
  logic [LINE_W-1:0] ret_data;

  // Downstream read responder: returns ret_data the cycle after an accepted request.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dn.m_re_valid <= 1'b0;
      dn.m_re_data  <= '0;
    end else begin
      dn.m_re_valid <= auto_ret && dn.m_r_req && dn.m_r_rdy;
      dn.m_re_data  <= ret_data;
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_inputs();
    up.r_req = '0; up.r_addr = '0; up.r_type = '0;
    up.w_req = '0; up.w_addr = '0; up.w_data = '0; up.w_type = '0; up.w_strb = '0;
    dn.m_r_rdy = 1'b0; dn.m_w_rdy = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clr_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic set_r(input int i, input logic [31:0] a, input logic [5:0] t);
    up.r_addr[i*32 +: 32] = a;
    up.r_type[i*6 +: 6]   = t;
  endtask

  task automatic set_w(input int i, input logic [31:0] a, input logic [255:0] d,
                       input logic [5:0] t, input logic [15:0] s);
    up.w_addr[i*32 +: 32]   = a;
    up.w_data[i*256 +: 256] = d;
    up.w_type[i*6 +: 6]     = t;
    up.w_strb[i*16 +: 16]   = s;
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_r_rdy"},    256'(up.r_rdy),    256'(0));
    chk({pfx, "_w_rdy"},    256'(up.w_rdy),    256'(0));
    chk({pfx, "_re_valid"}, 256'(up.re_valid), 256'(0));
    chk({pfx, "_re_data"},  up.re_data,        256'(0));
    chk({pfx, "_m_r_req"},  256'(dn.m_r_req),  256'(0));
    chk({pfx, "_m_r_addr"}, 256'(dn.m_r_addr), 256'(0));
    chk({pfx, "_m_r_type"}, 256'(dn.m_r_type), 256'(0));
    chk({pfx, "_m_w_req"},  256'(dn.m_w_req),  256'(0));
    chk({pfx, "_m_w_addr"}, 256'(dn.m_w_addr), 256'(0));
    chk({pfx, "_m_w_data"}, dn.m_w_data,       256'(0));
    chk({pfx, "_m_w_type"}, 256'(dn.m_w_type), 256'(0));
    chk({pfx, "_m_w_strb"}, 256'(dn.m_w_strb), 256'(0));
  endtask

  logic [255:0] d_a, d_b, d_c;
  logic [2:0]   gnt_seq [6];
  int           gnt_cyc [6];
  int           n_gnt;
  logic [2:0]   exp_gnt [6];

  initial begin
    d_a = {8{32'hDEAD_BEEF}};
    d_b = {8{32'h1111_2222}};
    d_c = {8{32'h3333_4444}};
    auto_ret = 1'b1;
    ret_data = '0;
    clr_inputs();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    // Requests held during reset must not be acknowledged.
    up.r_req = 3'b111;
    up.w_req = 3'b111;
    @(negedge clk);
    #1 chk_all_zero("reset");
    do_reset();

    // Single read from dcache.
    ret_data = d_a;
    up.r_req = 3'b010;
    set_r(1, 32'h8000_0040, 6'h15);
    #1 chk("rd1_r_rdy", 256'(up.r_rdy), 256'(3'b010));
    @(negedge clk);
    up.r_req = '0;
    #1 chk("rd1_m_r_req", 256'(dn.m_r_req), 256'(1));
    chk("rd1_m_r_addr", 256'(dn.m_r_addr), 256'(32'h8000_0040));
    chk("rd1_m_r_type", 256'(dn.m_r_type), 256'(6'h15));
    chk("rd1_r_rdy_busy", 256'(up.r_rdy), 256'(0));
    dn.m_r_rdy = 1'b1;
    @(negedge clk);
    dn.m_r_rdy = 1'b0;
    #1 chk("rd1_re_valid", 256'(up.re_valid), 256'(3'b010));
    chk("rd1_re_data", up.re_data, d_a);
    chk("rd1_m_r_req_clr", 256'(dn.m_r_req), 256'(0));
    @(negedge clk);
    #1 chk("rd1_re_valid_pulse", 256'(up.re_valid), 256'(0));

    // Contention: all three readers held, immediate downstream return.
    do_reset();
    dn.m_r_rdy = 1'b1;
    set_r(0, 32'h8000_0000, 6'h01);
    set_r(1, 32'h8000_0100, 6'h02);
    set_r(2, 32'h8000_0200, 6'h03);
    up.r_req = 3'b111;
    exp_gnt = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    for (int i = 0; i < 6; i++) begin
      gnt_seq[i] = '0;
      gnt_cyc[i] = -1;
    end
    n_gnt = 0;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (up.r_rdy != '0 && n_gnt < 6) begin
        gnt_seq[n_gnt] = up.r_rdy;
        gnt_cyc[n_gnt] = c;
        n_gnt++;
      end
      @(negedge clk);
    end
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("cont_gnt%0d", i), 256'(gnt_seq[i]), 256'(exp_gnt[i]));
      chk($sformatf("cont_cyc%0d", i), 256'(gnt_cyc[i]), 256'(3 * i));
    end

    // RAW hazard: read to the same line as a buffered write is held.
    do_reset();
    set_w(1, 32'h8000_1000, d_b, 6'h07, 16'hFFFF);
    set_r(0, 32'h8000_101C, 6'h08);
    up.w_req = 3'b010;
    up.r_req = 3'b001;
    #1 chk("raw_w_rdy", 256'(up.w_rdy), 256'(3'b010));
    chk("raw_r_rdy_acc", 256'(up.r_rdy), 256'(0));
    @(negedge clk);
    up.w_req = '0;
    for (int c = 0; c < 5; c++) begin
      #1 chk($sformatf("raw_blk%0d", c), 256'(up.r_rdy), 256'(0));
      @(negedge clk);
    end
    dn.m_w_rdy = 1'b1;
    #1 chk("raw_blk_drain", 256'(up.r_rdy), 256'(0));
    chk("raw_m_w_req", 256'(dn.m_w_req), 256'(1));
    @(negedge clk);
    dn.m_w_rdy = 1'b0;
    #1 chk("raw_r_rdy_rel", 256'(up.r_rdy), 256'(3'b001));
    chk("raw_m_w_req_clr", 256'(dn.m_w_req), 256'(0));
    @(negedge clk);
    up.r_req = '0;
    #1 chk("raw_m_r_addr", 256'(dn.m_r_addr), 256'(32'h8000_101C));

    // Adjacent line: no false hazard.
    do_reset();
    set_w(1, 32'h8000_1000, d_b, 6'h07, 16'hFFFF);
    set_r(0, 32'h8000_1020, 6'h08);
    up.w_req = 3'b010;
    up.r_req = 3'b001;
    #1 chk("nohaz_w_rdy", 256'(up.w_rdy), 256'(3'b010));
    chk("nohaz_r_rdy", 256'(up.r_rdy), 256'(3'b001));

    // Posted writes back-to-back with downstream always ready.
    do_reset();
    dn.m_w_rdy = 1'b1;
    set_w(1, 32'h8000_2000, d_b, 6'h11, 16'h00FF);
    set_w(2, 32'h8000_3000, d_c, 6'h22, 16'hF0F0);
    up.w_req = 3'b110;
    #1 chk("b2b_w_rdy0", 256'(up.w_rdy), 256'(3'b010));
    @(negedge clk);
    up.w_req = 3'b100;
    #1 chk("b2b_w_rdy1", 256'(up.w_rdy), 256'(0));
    chk("b2b_m_w_req1", 256'(dn.m_w_req), 256'(1));
    chk("b2b_m_w_addr1", 256'(dn.m_w_addr), 256'(32'h8000_2000));
    chk("b2b_m_w_data1", dn.m_w_data, d_b);
    chk("b2b_m_w_strb1", 256'(dn.m_w_strb), 256'(16'h00FF));
    @(negedge clk);
    #1 chk("b2b_w_rdy2", 256'(up.w_rdy), 256'(3'b100));
    @(negedge clk);
    up.w_req = '0;
    #1 chk("b2b_m_w_data2", dn.m_w_data, d_c);
    chk("b2b_m_w_strb2", 256'(dn.m_w_strb), 256'(16'hF0F0));
    chk("b2b_m_w_type2", 256'(dn.m_w_type), 256'(6'h22));

    // Reset while a read waits for data and a write is buffered.
    do_reset();
    auto_ret = 1'b0;
    dn.m_r_rdy = 1'b1;
    set_r(2, 32'h8000_2000, 6'h05);
    set_w(0, 32'h8000_3000, d_b, 6'h06, 16'h0F0F);
    up.r_req = 3'b100;
    up.w_req = 3'b001;
    #1 chk("rst_pre_r_rdy", 256'(up.r_rdy), 256'(3'b100));
    chk("rst_pre_w_rdy", 256'(up.w_rdy), 256'(3'b001));
    @(negedge clk);
    up.r_req = '0;
    up.w_req = '0;
    @(negedge clk);
    #1 chk("rst_pre_wbuf", 256'(dn.m_w_req), 256'(1));
    chk("rst_pre_wait", 256'(dn.m_r_req), 256'(0));
    up.r_req = 3'b011;
    up.w_req = 3'b001;
    rst_n = 1'b0;
    #1 chk_all_zero("rst_mid");
    @(negedge clk);
    clr_inputs();
    rst_n = 1'b1;
    @(negedge clk);
    auto_ret = 1'b1;
    ret_data = d_c;
    dn.m_r_rdy = 1'b1;
    set_r(2, 32'h8000_4000, 6'h09);
    up.r_req = 3'b100;
    #1 chk("post_r_rdy", 256'(up.r_rdy), 256'(3'b100));
    @(negedge clk);
    up.r_req = '0;
    #1 chk("post_m_r_addr", 256'(dn.m_r_addr), 256'(32'h8000_4000));
    @(negedge clk);
    #1 chk("post_re_valid", 256'(up.re_valid), 256'(3'b100));
    chk("post_re_data", up.re_data, d_c);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_arb.md
# sram_arb

Round-robin arbiter that shares one downstream SRAM-style line bus (the port facing the AXI bridge) among N_REQ upstream requesters: icache, dcache and the uncached LSU path. Reads and writes use independent channels. Each channel has one transaction in flight. Writes are posted through a one-entry buffer. A read to a line with a buffered, undrained write is held until that write drains, so a read never returns stale data.

## Interface
- N_REQ, 3: number of upstream requesters; index 0 = icache, 1 = dcache, 2 = LSU.
- LINE_OFF, 5: byte-offset bits of a 256-bit line; hazard compare uses addr[31:LINE_OFF].
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- r_req  in  N_REQ  per-requester read request.
- r_addr  in  32*N_REQ  read address; slice i is requester i.
- r_type  in  6*N_REQ  read type, passed through unchanged.
- r_rdy  out  N_REQ  read accepted; one-hot or zero.
- re_data  out  256  read data, broadcast to all requesters.
- re_valid  out  N_REQ  one-cycle read-return strobe, one-hot.
- w_req  in  N_REQ  per-requester write request.
- w_addr  in  32*N_REQ  write address.
- w_data  in  256*N_REQ  write data.
- w_type  in  6*N_REQ  write type.
- w_strb  in  16*N_REQ  write strobes.
- w_rdy  out  N_REQ  write accepted (posted); one-hot or zero.
- m_r_req / m_r_addr / m_r_type  out  1/32/6  downstream read request.
- m_r_rdy  in  1  downstream read accept.
- m_re_data / m_re_valid  in  256/1  downstream read return.
- m_w_req / m_w_addr / m_w_data / m_w_type / m_w_strb  out  1/32/256/6/16  downstream write.
- m_w_rdy  in  1  downstream write accept.

## Operation
- Handshake:
  - Upstream transfer occurs on req && rdy in the same cycle.
  - A requester holds req and its payload stable until rdy.
  - Downstream transfer occurs on m_*_req && m_*_rdy.
- Read FSM:
  - R_IDLE: the rr_arbiter picks a winner among r_req. If the read is not blocked, assert r_rdy[win] combinationally, latch addr, type and id, then go to R_ISSUE.
  - R_ISSUE: drive m_r_req = 1 with the latched fields. On m_r_rdy, go to R_WAIT.
  - R_WAIT: on m_re_valid, set re_valid[id] = 1 and re_data = m_re_data in the same cycle, then go to R_IDLE.
- Write FSM:
  - W_IDLE: the rr_arbiter picks a winner among w_req. Assert w_rdy[win] combinationally, latch all fields into the buffer (wbuf_vld = 1), then go to W_ISSUE.
  - W_ISSUE: drive m_w_* from the buffer. On m_w_rdy, clear wbuf_vld and go to W_IDLE.
- Hazard: the read winner is blocked when its addr[31:5] equals the line of either of these:
  - the buffered write, while wbuf_vld = 1;
  - the write being accepted this cycle.
- While blocked, r_rdy = 0, the read pointer does not advance, and the read is retried every cycle.
- Round-robin:
  - The read and write pointers are independent.
  - After a grant to index i, priority starts at (i+1) mod N_REQ.
  - A pointer advances only on an actual handshake.
  - Reset priority order is 0, 1, 2.
- Simultaneous events:
  - A read and a write from the same or different requesters may both be accepted in one cycle unless a hazard applies.
  - m_re_valid arriving while in R_ISSUE is a protocol error: ignore it and flag it with an assertion.
- Reset:
  - Asynchronous. Both FSMs go to IDLE, wbuf_vld = 0, pointers = 0.
  - An in-flight downstream transaction is abandoned; downstream is reset by the same rst_n.
- Reset values: r_rdy, w_rdy, re_valid, m_r_req and m_w_req are 0. re_data, m_r_addr, m_r_type, m_w_addr, m_w_data, m_w_type and m_w_strb are 0.

## Timing
- Read:
  - Cycle 0: accept (r_rdy).
  - Cycle 1 onward: m_r_req.
  - Return: re_valid in the same cycle as m_re_valid.
  - Minimum spacing: 3 cycles per read.
- Write:
  - Cycle 0: accept (w_rdy).
  - Cycle 1 onward: m_w_req.
  - The next write can be accepted in the cycle after m_w_rdy, giving a maximum of 1 write per 2 cycles.
- Hazard stall: a blocked read can be accepted no earlier than the cycle after the blocking write's m_w_rdy.
- r_rdy and w_rdy are combinational from req, FSM state and pointer. All m_* outputs are registered.

## Structure
- Package sram_arb_pkg:
  - N_REQ, LINE_OFF, TYPE_W = 6, LINE_W = 256, STRB_W = 16.
  - Enums r_state_t {R_IDLE, R_ISSUE, R_WAIT} and w_state_t {W_IDLE, W_ISSUE}.
- Sub-module rr_arbiter:
  - Input: a request vector and an advance enable.
  - Output: a one-hot grant.
  - Owns its own pointer.
  - Instantiated twice, once per channel.

## Test plan
- Single read: r_req[1] at 0x8000_0040. Required: r_rdy[1] same cycle; m_r_req next cycle with addr 0x8000_0040. After m_re_valid with data D, re_valid = 3'b010 with re_data = D; no other re_valid bit rises.
- Contention: all three r_req held continuously, downstream returns immediately. Required grant order 0, 1, 2, 0, 1, 2; no requester starves.
- RAW hazard: w_req[1] at 0x8000_1000 accepted; r_req[0] at 0x8000_101C held; m_w_rdy delayed 5 cycles. Required: r_rdy[0] stays 0 until the cycle after m_w_rdy.
- No false hazard: the same sequence with the read at 0x8000_1020. Required: read accepted in the same cycle as the write.
- Posted write back-to-back: w_req[1] and w_req[2] both held, m_w_rdy tied to 1. Required: w_rdy order 1 then 2, two cycles apart; m_w_strb and m_w_data match each requester.
- Reset mid-op: deassert rst_n while in R_WAIT with wbuf_vld = 1. Required: all outputs 0 immediately; after release, a fresh read completes normally.
